// File: rtl/asdpmem.sv
// asdpmem: dual-port word memory with a synchronous write port A and an
// asynchronous read port B; contents are never reset.
module asdpmem #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             ena,
  input  logic             wea,
  input  logic [DEPTH-1:0] addra,
  input  logic [WIDTH-1:0] dia,
  input  logic [DEPTH-1:0] addrb,
  output logic [WIDTH-1:0] dob
);
  logic [WIDTH-1:0] mem [1<<DEPTH];
  always_ff @(posedge clk)
    if (ena && wea) mem[addra] <= dia;
  assign dob = mem[addrb];
endmodule

// File: rtl/asdpmem_fifo.sv
// asdpmem_fifo: single-clock show-ahead FIFO controller driving one asdpmem
// as storage; port A writes, port B reads asynchronously for zero read latency.
module asdpmem_fifo #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32,
  parameter int AFULL = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int CAPACITY = 1 << DEPTH;
  logic [DEPTH-1:0] wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;
  assign empty       = count == '0;
  assign full        = count == (DEPTH+1)'(CAPACITY);
  assign almost_full = count >= (DEPTH+1)'(AFULL);
  // flush suppresses acceptance so no memory write happens in a flush cycle
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + DEPTH'(1);
      count <= (wr_ok && !rd_ok) ? count + (DEPTH+1)'(1) :
               (rd_ok && !wr_ok) ? count - (DEPTH+1)'(1) : count;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  asdpmem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk  (clk),
    .ena  (1'b1),
    .wea  (wr_ok),
    .addra(wr_ptr),
    .dia  (wr_data),
    .addrb(rd_ptr),
    .dob  (rd_data)
  );
endmodule

// File: tb/tb_asdpmem_fifo.sv
// tb_asdpmem_fifo: directed scenarios plus random traffic checked against a
// queue-based FIFO model (capacity 4, almost-full at 3).
module tb_asdpmem_fifo;
  localparam int DEPTH = 2, WIDTH = 32, AFULL = 3, CAP = 4;
  logic clk = 0, rst_n = 0, flush = 0, wr_en = 0, rd_en = 0;
  logic [WIDTH-1:0] wr_data = '0, rd_data;
  logic full, almost_full, empty, overflow, underflow;
  logic [DEPTH:0] count;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  logic m_ov = 0, m_un = 0;

  asdpmem_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == CAP));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_un));
    if (n != 0) chk({tag, ".rd_data"}, rd_data, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_un = 0;
  endtask

  // one clock: drive, take the edge, advance the model, check 1 time unit later
  task automatic step(input string tag, input logic w, input logic [31:0] d,
                      input logic r, input logic f);
    bit wok, rok;
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    if (f) model_reset();
    else begin
      wok = w && q.size() < CAP;
      rok = r && q.size() > 0;
      if (w && !wok) m_ov = 1;
      if (r && !rok) m_un = 1;
      if (rok) void'(q.pop_front());
      if (wok) q.push_back(d);
    end
    #1;
    check_all(tag);
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    check_all("reset");
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0);

    step("s2.w1", 1, 32'h11223344, 0, 0);
    step("s2.w2", 1, 32'h55667788, 0, 0);
    step("s2.pop", 0, 0, 1, 0);
    step("s2.pop2", 0, 0, 1, 0);

    for (int i = 0; i < 5; i++) step("s3.wr", 1, 32'hA0 + i, 0, 0);
    for (int i = 0; i < 4; i++) step("s3.pop", 0, 0, 1, 0);
    step("s3.flush", 0, 0, 0, 1);

    step("s4.f1", 1, 32'hB0, 0, 0);
    step("s4.f2", 1, 32'hB1, 0, 0);
    for (int i = 0; i < 6; i++) step("s4.rw", 1, 32'hB2 + i, 1, 0);
    step("s4.pop", 0, 0, 1, 0);
    step("s4.pop", 0, 0, 1, 0);

    step("s5.under", 0, 0, 1, 0);
    step("s5.wr", 1, 32'hC0, 0, 0);
    step("s5.flush", 0, 0, 0, 1);
    step("s5.wr2", 1, 32'hC1, 0, 0);
    step("s5.pop", 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) step("s6.fill", 1, 32'hD0 + i, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("s6.async");
    #1 rst_n = 1;
    step("s6.w1", 1, 32'h11223344, 0, 0);
    step("s6.w2", 1, 32'h55667788, 0, 0);
    step("s6.pop", 0, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
